// File: rtl/seg7_scan_driver_if.sv
// Bundle of display-side signals between the controller and seg7_scan_driver.
// The controller (master) supplies value/dp/blank_mask/load; the driver
// (slave) returns the pin-level segment, decimal-point and anode drives.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank_mask;
  logic                load;
  logic [6:0]          seg;
  logic                dp_out;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output value, dp, blank_mask, load,
    input  seg, dp_out, an, frame_done
  );

  modport slave (
    input  value, dp, blank_mask, load,
    output seg, dp_out, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver.
// A prescaler splits time into DIV-cycle slots; each slot lights one digit
// after BLANK dark cycles (anti-ghosting). New display contents are staged in
// a pending register and only committed at a frame boundary, so a digit never
// changes mid-scan. All pin outputs are registered (1 cycle latency).
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to darken leading zeros.
module seg7_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 16
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                pend_q;
  logic [4*DIGITS-1:0] pend_val_q;
  logic [DIGITS-1:0]   pend_dp_q;
  logic [DIGITS-1:0]   pend_bm_q;
  logic [4*DIGITS-1:0] disp_val_q;
  logic [DIGITS-1:0]   disp_dp_q;
  logic [DIGITS-1:0]   disp_bm_q;

  logic [6:0]          seg_q, seg_d;
  logic                dp_out_q, dp_out_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_end;
  logic                boundary;
  logic [DIGITS-1:0]   lz_dark;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_dark;
  logic                in_blank;

  assign slot_end = (cnt_q == CNT_W'(DIV - 1));
  assign boundary = slot_end && (idx_q == IDX_W'(DIGITS - 1));
  assign in_blank = (BLANK > 0) && (cnt_q < CNT_W'(BLANK));

  // Leading-zero suppression: digits above the top nonzero nibble go dark.
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic zero_run;
  always_comb begin
    lz_dark  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (disp_val_q[i*4 +: 4] == 4'h0);
      lz_dark[i] = zero_run;
    end
  end
`else
  assign lz_dark = '0;
`endif

  // Select the current digit and form the next registered pin values.
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib  = disp_val_q[i*4 +: 4];
        cur_dp   = disp_dp_q[i];
        cur_dark = disp_bm_q[i] | lz_dark[i];
      end
    end
    seg_d        = cur_dark ? 7'h7F : hex_to_seg(cur_nib);
    dp_out_d     = cur_dark ? 1'b1 : ~cur_dp;
    an_d         = in_blank ? '1 : ~(DIGITS'(1) << idx_q);
    frame_done_d = boundary;
  end

  // Prescaler and digit index: one slot per DIV cycles, wrapping per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (slot_end) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Load staging and frame-synchronous commit to the display register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_bm_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      disp_bm_q  <= '0;
    end else begin
      if (bus.load) begin
        pend_val_q <= bus.value;
        pend_dp_q  <= bus.dp;
        pend_bm_q  <= bus.blank_mask;
      end
      if (boundary) begin
        // A load on the boundary bypasses the pending stage entirely.
        if (bus.load) begin
          disp_val_q <= bus.value;
          disp_dp_q  <= bus.dp;
          disp_bm_q  <= bus.blank_mask;
        end else if (pend_q) begin
          disp_val_q <= pend_val_q;
          disp_dp_q  <= pend_dp_q;
          disp_bm_q  <= pend_bm_q;
        end
        pend_q <= 1'b0;
      end else if (bus.load) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Registered pin drivers; reset forces the display fully dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q        <= 7'h7F;
      dp_out_q     <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_out_q     <= dp_out_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp_out     = dp_out_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (DIGITS=4, DIV=4, BLANK=1).
// Hand-computed vector table plus directed corner sequences, and a
// cycle-by-cycle reference model under random load traffic.
module tb_seg7_scan_driver;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int BLANK  = 1;
  localparam int FRAME  = DIGITS * DIV;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: position in the frame comes straight from the number of
  // clock edges since reset; display contents follow the commit rules.
  int unsigned k;
  int          pos, cnt, idx, msd;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, m_bm, p_dp, p_bm;
  bit          m_pend, dark;
  logic [6:0]  e_seg;
  logic        e_dpo, e_fd;
  logic [3:0]  e_an;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; m_val = '0; m_dp = '0; m_bm = '0; m_pend = 0;
      p_val = '0; p_dp = '0; p_bm = '0;
      e_seg = 7'h7F; e_dpo = 1'b1; e_an = 4'hF; e_fd = 1'b0;
    end else begin
      pos = k % FRAME;
      cnt = k % DIV;
      idx = (k / DIV) % DIGITS;
      msd = 0;
      for (int i = 0; i < DIGITS; i++) if (m_val[i*4 +: 4] != 4'h0) msd = i;
      dark  = m_bm[idx] || (LZ && idx > msd);
      e_seg = dark ? 7'h7F : dec[m_val[idx*4 +: 4]];
      e_dpo = dark ? 1'b1 : !m_dp[idx];
      e_an  = (cnt < BLANK) ? 4'hF : ~(4'b0001 << idx);
      e_fd  = (pos == FRAME - 1);
      if (pos == FRAME - 1) begin
        if (bus.load) begin m_val = bus.value; m_dp = bus.dp; m_bm = bus.blank_mask; end
        else if (m_pend) begin m_val = p_val; m_dp = p_dp; m_bm = p_bm; end
        m_pend = 0;
      end else if (bus.load) begin
        p_val = bus.value; p_dp = bus.dp; p_bm = bus.blank_mask; m_pend = 1;
      end
      k++;
    end
  end

  bit chk_en = 0;
  bit seen79 = 0;
  bit mon79  = 0;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model seg", bus.seg, e_seg);
      check("model dp_out", bus.dp_out, e_dpo);
      check("model an", bus.an, e_an);
      check("model frame_done", bus.frame_done, e_fd);
    end
    if (mon79 && bus.seg == 7'h79) seen79 = 1;
  end

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  bm;
    logic [27:0] segs;   // {d3,d2,d1,d0}
    logic [3:0]  dpo;    // dp_out per digit
  } vec_t;

  vec_t vec [6];

  task automatic wait_fd();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.frame_done && n < 40);
    check("frame_done wait", bus.frame_done, 1);
  endtask

  task automatic load_one(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    bus.value = v; bus.dp = d; bus.blank_mask = b; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Called right after a frame_done negedge: walks one frame, checking each digit.
  task automatic capture(input vec_t v, input string name);
    logic [3:0] ea;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      if (j == 0) check({name, " slot blank an"}, bus.an, 4'hF);
      if (j % DIV == 1) begin
        ea = ~(4'b0001 << (j / DIV));
        check({name, " an"}, bus.an, ea);
        check({name, " seg"}, bus.seg, v.segs[(j/DIV)*7 +: 7]);
        check({name, " dp_out"}, bus.dp_out, v.dpo[j/DIV]);
      end
    end
  endtask

  logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  vec_t all24;

  initial begin
    vec[0] = '{16'h12AF, 4'h0, 4'h0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    vec[1] = '{16'h0050, 4'h1, 4'h0, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1110};
    vec[2] = '{16'h0000, 4'hF, 4'h0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110};
`else
    vec[1] = '{16'h0050, 4'h1, 4'h0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1110};
    vec[2] = '{16'h0000, 4'hF, 4'h0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000};
`endif
    vec[3] = '{16'hBE00, 4'h0, 4'h0, {7'h03, 7'h06, 7'h40, 7'h40}, 4'hF};
    vec[4] = '{16'h3467, 4'h5, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF};
    vec[5] = '{16'h89CD, 4'hA, 4'h4, {7'h00, 7'h7F, 7'h46, 7'h21}, 4'b0101};
    all24  = '{16'h2222, 4'h0, 4'h0, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF};

    bus.value = '0; bus.dp = '0; bus.blank_mask = '0; bus.load = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("reset seg", bus.seg, 7'h7F);
    check("reset dp_out", bus.dp_out, 1);
    check("reset an", bus.an, 4'hF);
    check("reset frame_done", bus.frame_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;

    // Reset release, no load: scan order, blank slot start, frame period
    for (int j = 0; j < 2 * FRAME; j++) begin
      @(negedge clk);
      check("scan an", bus.an, (j % DIV < BLANK) ? 4'hF : an_seq[(j / DIV) % DIGITS]);
      check("scan seg", bus.seg, 7'h40);
      check("scan frame_done", bus.frame_done, (j % FRAME) == FRAME - 1);
    end

    // Two loads within one frame: only the later one is ever shown
    mon79 = 1;
    repeat (2) @(negedge clk);
    load_one(16'h1111, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    load_one(16'h2222, 4'h0, 4'h0);
    wait_fd();
    capture(all24, "double load");
    mon79 = 0;
    check("1111 never shown", seen79, 0);

    // Load on the exact boundary cycle goes straight to the display
    repeat (FRAME - 1) @(negedge clk);
    load_one(16'h0005, 4'h0, 4'h0);
    check("boundary frame_done", bus.frame_done, 1);
    @(negedge clk);
    check("boundary seg d0 blank", bus.seg, 7'h12);
    check("boundary an blank", bus.an, 4'hF);
    @(negedge clk);
    check("boundary seg d0", bus.seg, 7'h12);
    check("boundary an d0", bus.an, 4'hE);
    wait_fd();

    // Vector table: mid-frame load (idx 1), visible from the next frame
    for (int e = 0; e < 6; e++) begin
      repeat (5) @(negedge clk);
      load_one(vec[e].val, vec[e].dp, vec[e].bm);
      wait_fd();
      capture(vec[e], $sformatf("vec%0d", e));
    end

    // Asynchronous reset mid-frame at idx 2, cnt 2
    repeat (10) @(negedge clk);
    check("pre-reset an", bus.an, 4'hB);
    #2 rst = 1'b1;
    #1;
    check("midreset seg", bus.seg, 7'h7F);
    check("midreset an", bus.an, 4'hF);
    check("midreset frame_done", bus.frame_done, 0);
    check("midreset dp_out", bus.dp_out, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      if (j % DIV == 1) begin
        check("post-reset an", bus.an, an_seq[j / DIV]);
        check("post-reset seg", bus.seg, 7'h40);
      end
    end

    // Random load traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      bus.load       = ($urandom_range(0, 5) == 0);
      bus.value      = 16'($urandom);
      bus.dp         = 4'($urandom);
      bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    end
    @(negedge clk);
    bus.load = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
